// File: rtl/regfile_2w2r.sv
// regfile_2w2r: two-write / two-read register file with a hardwired-zero
// register 0, port-4 write priority, out-of-range address protection, a
// registered write-collision flag and a one-entry-per-cycle clear sequencer.
//
// Parameters: WIDTH (data bits), DEPTH (registers, 2..2**REG_ADDR),
//             REG_ADDR (address bits).
// Ports:
//   CLK           clock, all state updates on the rising edge
//   RST           synchronous active-high reset; starts a clear sequence
//   CLR           single-cycle request to start (or restart) a clear sequence
//   A1/A2         read addresses; RD1/RD2 combinational read data
//   A3/WD3/WE3    write port 3
//   A4/WD4/WE4    write port 4 (wins over port 3 on the same address)
//   BUSY          clear sequence in progress
//   COLLIDE       previous cycle had a same-address dual write
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to the read ports.
module regfile_2w2r #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned REG_ADDR = 5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CLR,
  input  logic [REG_ADDR-1:0] A1,
  input  logic [REG_ADDR-1:0] A2,
  input  logic [REG_ADDR-1:0] A3,
  input  logic [WIDTH-1:0]    WD3,
  input  logic                WE3,
  input  logic [REG_ADDR-1:0] A4,
  input  logic [WIDTH-1:0]    WD4,
  input  logic                WE4,
  output logic [WIDTH-1:0]    RD1,
  output logic [WIDTH-1:0]    RD2,
  output logic                BUSY,
  output logic                COLLIDE
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] CLEARING = 1'b1;

  logic [0:0]          state;
  logic [REG_ADDR-1:0] ptr;
  logic                collide_q;
  logic [WIDTH-1:0]    mem [DEPTH];

  logic busy;
  logic we3_ok;
  logic we4_ok;
  logic collision;

  // Nonzero and inside the array: the only addresses that may be stored/read.
  function automatic logic addr_ok(input logic [REG_ADDR-1:0] a);
    return (a != '0) && (32'(a) < DEPTH);
  endfunction

  // Array index; only meaningful once addr_ok() has accepted the address.
  function automatic logic [IW-1:0] idx(input logic [REG_ADDR-1:0] a);
    return a[IW-1:0];
  endfunction

  assign busy      = (state == CLEARING);
  assign we3_ok    = WE3 && !busy && !RST && addr_ok(A3);
  assign we4_ok    = WE4 && !busy && !RST && addr_ok(A4);
  assign collision = we3_ok && we4_ok && (A3 == A4);

  assign BUSY    = busy;
  assign COLLIDE = collide_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= CLEARING;
      ptr       <= '0;
      collide_q <= 1'b0;
    end else begin
      // A collision in the CLR cycle must not show while the clear runs.
      collide_q <= collision && !CLR;
      if (CLR) begin
        state <= CLEARING;
        ptr   <= '0;
      end else if (state == CLEARING) begin
        if (32'(ptr) == DEPTH - 1) begin
          state <= IDLE;
          ptr   <= '0;
        end else begin
          ptr <= ptr + 1'b1;
        end
      end
    end
  end

  // Array has no reset; the clear sequencer zeroes it one entry per edge.
  // Port 4 is assigned last so it wins a same-address dual write.
  always_ff @(posedge CLK) begin
    if (!RST && state == CLEARING) begin
      mem[idx(ptr)] <= '0;
    end else begin
      if (we3_ok) mem[idx(A3)] <= WD3;
      if (we4_ok) mem[idx(A4)] <= WD4;
    end
  end

  always_comb begin
    RD1 = '0;
    if (!busy && addr_ok(A1)) begin
      RD1 = mem[idx(A1)];
`ifdef REGFILE_BYPASS_EN
      if (we3_ok && A3 == A1) RD1 = WD3;
      if (we4_ok && A4 == A1) RD1 = WD4;
`endif
    end
  end

  always_comb begin
    RD2 = '0;
    if (!busy && addr_ok(A2)) begin
      RD2 = mem[idx(A2)];
`ifdef REGFILE_BYPASS_EN
      if (we3_ok && A3 == A2) RD2 = WD3;
      if (we4_ok && A4 == A2) RD2 = WD4;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_2w2r.sv
// Directed bench for regfile_2w2r (DEPTH=32, REG_ADDR=6 so that out-of-range
// addresses such as 40 are reachable). Inputs change on the falling edge and
// outputs are checked 1 time unit later.
module tb_regfile_2w2r;

  logic        CLK = 1'b0;
  logic        RST, CLR;
  logic [5:0]  A1, A2, A3, A4;
  logic [31:0] WD3, WD4;
  logic        WE3, WE4;
  logic [31:0] RD1, RD2;
  logic        BUSY, COLLIDE;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_2w2r #(.WIDTH(32), .DEPTH(32), .REG_ADDR(6)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR),
    .A1(A1), .A2(A2),
    .A3(A3), .WD3(WD3), .WE3(WE3),
    .A4(A4), .WD4(WD4), .WE4(WE4),
    .RD1(RD1), .RD2(RD2), .BUSY(BUSY), .COLLIDE(COLLIDE)
  );

  always #5 CLK = ~CLK;

  task automatic next_cycle();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    int cnt;
    RST = 1'b1; CLR = 1'b0; WE3 = 1'b0; WE4 = 1'b0;
    A1 = 6'd31; A2 = 6'd5; A3 = '0; A4 = '0; WD3 = '0; WD4 = '0;
    next_cycle();
    RST = 1'b0;
    #1;
    n_cmp++; if (BUSY !== 1'b1)    begin n_bad++; $display("FAIL reset_busy got=%b exp=1", BUSY); end
    n_cmp++; if (COLLIDE !== 1'b0) begin n_bad++; $display("FAIL reset_collide got=%b exp=0", COLLIDE); end
    n_cmp++; if (RD1 !== 32'h0)    begin n_bad++; $display("FAIL reset_rd1 got=%h exp=0", RD1); end
    n_cmp++; if (RD2 !== 32'h0)    begin n_bad++; $display("FAIL reset_rd2 got=%h exp=0", RD2); end
    // Write attempted throughout the clear must be lost.
    WE3 = 1'b1; A3 = 6'd5; WD3 = 32'hDEADBEEF;
    cnt = 0;
    while (BUSY === 1'b1 && cnt < 200) begin
      cnt++;
      next_cycle();
      #1;
    end
    WE3 = 1'b0;
    n_cmp++; if (cnt != 32) begin n_bad++; $display("FAIL reset_busy_len got=%0d exp=32", cnt); end
    A1 = 6'd5;
    #1;
    n_cmp++; if (RD1 !== 32'h0) begin n_bad++; $display("FAIL busy_write_lost got=%h exp=0", RD1); end
  endtask

  task automatic test_dual_write();
    next_cycle();
    WE3 = 1'b1; A3 = 6'd7; WD3 = 32'h11;
    WE4 = 1'b1; A4 = 6'd9; WD4 = 32'h22;
    next_cycle();
    WE3 = 1'b0; WE4 = 1'b0; A1 = 6'd7; A2 = 6'd9;
    #1;
    n_cmp++; if (RD1 !== 32'h11)   begin n_bad++; $display("FAIL dual_rd1 got=%h exp=11", RD1); end
    n_cmp++; if (RD2 !== 32'h22)   begin n_bad++; $display("FAIL dual_rd2 got=%h exp=22", RD2); end
    n_cmp++; if (COLLIDE !== 1'b0) begin n_bad++; $display("FAIL dual_collide got=%b exp=0", COLLIDE); end
  endtask

  task automatic test_collide();
    next_cycle();
    WE3 = 1'b1; A3 = 6'd4; WD3 = 32'hAAAA;
    WE4 = 1'b1; A4 = 6'd4; WD4 = 32'h5555;
    next_cycle();
    WE3 = 1'b0; WE4 = 1'b0; A1 = 6'd4;
    #1;
    n_cmp++; if (RD1 !== 32'h5555) begin n_bad++; $display("FAIL collide_prio got=%h exp=5555", RD1); end
    n_cmp++; if (COLLIDE !== 1'b1) begin n_bad++; $display("FAIL collide_set got=%b exp=1", COLLIDE); end
    next_cycle();
    #1;
    n_cmp++; if (COLLIDE !== 1'b0) begin n_bad++; $display("FAIL collide_clear got=%b exp=0", COLLIDE); end
  endtask

  task automatic test_zero_oor();
    next_cycle();
    WE3 = 1'b1; A3 = 6'd0;  WD3 = 32'hFFFFFFFF;
    WE4 = 1'b1; A4 = 6'd40; WD4 = 32'hFFFFFFFF;
    A1 = 6'd0; A2 = 6'd40;
    #1;
    n_cmp++; if (RD1 !== 32'h0) begin n_bad++; $display("FAIL zero_rd_same got=%h exp=0", RD1); end
    n_cmp++; if (RD2 !== 32'h0) begin n_bad++; $display("FAIL oor_rd_same got=%h exp=0", RD2); end
    next_cycle();
    // Both ports at the same discarded addresses: no collision may be flagged.
    A3 = 6'd40; A4 = 6'd40;
    #1;
    n_cmp++; if (RD1 !== 32'h0) begin n_bad++; $display("FAIL zero_rd got=%h exp=0", RD1); end
    n_cmp++; if (RD2 !== 32'h0) begin n_bad++; $display("FAIL oor_rd got=%h exp=0", RD2); end
    next_cycle();
    A3 = 6'd0; A4 = 6'd0;
    next_cycle();
    WE3 = 1'b0; WE4 = 1'b0;
    A1 = 6'd8; A2 = 6'd7;  // 8 aliases 40 in the low index bits
    #1;
    n_cmp++; if (COLLIDE !== 1'b0) begin n_bad++; $display("FAIL oor_collide got=%b exp=0", COLLIDE); end
    n_cmp++; if (RD1 !== 32'h0)    begin n_bad++; $display("FAIL oor_alias got=%h exp=0", RD1); end
    n_cmp++; if (RD2 !== 32'h11)   begin n_bad++; $display("FAIL oor_keep7 got=%h exp=11", RD2); end
    A1 = 6'd4; A2 = 6'd9;
    #1;
    n_cmp++; if (RD1 !== 32'h5555) begin n_bad++; $display("FAIL oor_keep4 got=%h exp=5555", RD1); end
    n_cmp++; if (RD2 !== 32'h22)   begin n_bad++; $display("FAIL oor_keep9 got=%h exp=22", RD2); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp1, exp2;
`ifdef REGFILE_BYPASS_EN
    exp1 = 32'h1234;
    exp2 = 32'h0000BBBB;
`else
    exp1 = 32'h0;
    exp2 = 32'h0;
`endif
    next_cycle();
    WE3 = 1'b1; A3 = 6'd3; WD3 = 32'h1234; A1 = 6'd3;
    #1;
    n_cmp++; if (RD1 !== exp1) begin n_bad++; $display("FAIL bypass_same got=%h exp=%h", RD1, exp1); end
    next_cycle();
    WE3 = 1'b0; A1 = 6'd3;
    #1;
    n_cmp++; if (RD1 !== 32'h1234) begin n_bad++; $display("FAIL bypass_after got=%h exp=1234", RD1); end
    WE3 = 1'b1; A3 = 6'd10; WD3 = 32'hAAAA0000;
    WE4 = 1'b1; A4 = 6'd10; WD4 = 32'h0000BBBB;
    A2 = 6'd10;
    #1;
    n_cmp++; if (RD2 !== exp2) begin n_bad++; $display("FAIL bypass_prio got=%h exp=%h", RD2, exp2); end
    next_cycle();
    WE3 = 1'b0; WE4 = 1'b0;
    #1;
    n_cmp++; if (RD2 !== 32'h0000BBBB) begin n_bad++; $display("FAIL bypass_prio_after got=%h exp=0000bbbb", RD2); end
    n_cmp++; if (COLLIDE !== 1'b1) begin n_bad++; $display("FAIL bypass_collide got=%b exp=1", COLLIDE); end
  endtask

  task automatic test_clear_restart();
    int cnt;
    int bad_regs;
    for (int i = 1; i < 32; i += 2) begin
      next_cycle();
      WE3 = 1'b1; A3 = 6'(i);     WD3 = 32'hC0DE0000 + 32'(i);
      WE4 = (i + 1 < 32); A4 = 6'(i + 1); WD4 = 32'hC0DE0000 + 32'(i + 1);
    end
    next_cycle();
    WE3 = 1'b0; WE4 = 1'b0; A1 = 6'd17; A2 = 6'd30;
    #1;
    n_cmp++; if (RD1 !== 32'hC0DE0011) begin n_bad++; $display("FAIL fill_r17 got=%h exp=c0de0011", RD1); end
    n_cmp++; if (RD2 !== 32'hC0DE001E) begin n_bad++; $display("FAIL fill_r30 got=%h exp=c0de001e", RD2); end
    CLR = 1'b1;
    next_cycle();
    CLR = 1'b0;
    #1;
    cnt = 0;
    while (BUSY === 1'b1 && cnt < 200) begin
      cnt++;
      CLR = (cnt == 10);
      next_cycle();
      #1;
    end
    CLR = 1'b0;
    n_cmp++; if (cnt != 42) begin n_bad++; $display("FAIL clr_restart_len got=%0d exp=42", cnt); end
    bad_regs = 0;
    for (int i = 0; i < 32; i++) begin
      A1 = 6'(i); A2 = 6'(31 - i);
      #1;
      if (RD1 !== 32'h0 || RD2 !== 32'h0) bad_regs++;
    end
    n_cmp++; if (bad_regs != 0) begin n_bad++; $display("FAIL clr_all_zero got=%0d nonzero reads exp=0", bad_regs); end
  endtask

  task automatic test_rst_midclear();
    int cnt;
    next_cycle();
    CLR = 1'b1;
    next_cycle();
    CLR = 1'b0;
    #1;
    cnt = 0;
    while (BUSY === 1'b1 && cnt < 200) begin
      cnt++;
      RST = (cnt == 5);
      next_cycle();
      #1;
    end
    RST = 1'b0;
    n_cmp++; if (cnt != 37) begin n_bad++; $display("FAIL rst_midclear_len got=%0d exp=37", cnt); end
  endtask

  initial begin
    test_reset();
    test_dual_write();
    test_collide();
    test_zero_oor();
    test_bypass();
    test_clear_restart();
    test_rst_midclear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_2w2r.md
# regfile_2w2r

Parametrised two-write/two-read register file for the single-cycle MIPS datapath and its dual-issue follow-ons. Adds a hardwired-zero register 0, deterministic write-port priority, out-of-range address protection, a write-collision flag and a hardware clear sequencer that zeroes the array one entry per cycle instead of with a full-array reset fan-out. Sits between the decode stage (addresses) and the ALU/write-back stages.

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 32, number of registers; must satisfy 2 ≤ DEPTH ≤ 2^REG_ADDR
- REG_ADDR, 5, address width in bits
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- CLR  in  1  single-cycle request to start a clear sequence
- A1  in  REG_ADDR  read address, port 1
- A2  in  REG_ADDR  read address, port 2
- A3  in  REG_ADDR  write address, port 3
- WD3  in  WIDTH  write data, port 3
- WE3  in  1  write enable, port 3
- A4  in  REG_ADDR  write address, port 4
- WD4  in  WIDTH  write data, port 4
- WE4  in  1  write enable, port 4
- RD1  out  WIDTH  read data, port 1 (combinational)
- RD2  out  WIDTH  read data, port 2 (combinational)
- BUSY  out  1  clear sequence in progress (registered)
- COLLIDE  out  1  registered flag: previous cycle had a same-address dual write

## Operation
- State machine: IDLE, CLEARING. A clear pointer PTR (REG_ADDR bits) is used only in CLEARING.
- RST high at an edge: enter CLEARING, PTR←0, BUSY←1, COLLIDE←0. Array contents are not reset directly.
- CLEARING, RST low: mem[PTR]←0, PTR←PTR+1. At PTR = DEPTH−1, that entry is written, then the state goes to IDLE and BUSY←0.
- CLR high in IDLE: enter CLEARING, PTR←0, BUSY←1.
- CLR high in CLEARING: restart with PTR←0.
- While BUSY=1:
  - WE3 and WE4 are ignored.
  - RD1 and RD2 read as 0.
  - COLLIDE is held at 0.
- Register 0:
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0 in every state.
- Out-of-range addresses (≥ DEPTH):
  - Writes are discarded.
  - Reads return 0.
- Dual write, different addresses: both commit on the same edge.
- Dual write, same valid nonzero address: port 4 wins. COLLIDE←1 for exactly the following cycle, otherwise 0.
- Reads are asynchronous from the array. Bypass behaviour is governed by Configuration.

## Timing
- Read latency: combinational, 0 cycles.
- Write latency: committed at the edge where WE is sampled high.
- Clear duration: BUSY is high for exactly DEPTH cycles after the first edge with RST low (or after the CLR edge), then drops. The first accepted write is on the edge after BUSY is seen low.
- Reset values:
  - BUSY = 1
  - COLLIDE = 0
  - RD1 = RD2 = 0
  - state = CLEARING, PTR = 0
- RST asserted mid-clear: the sequence restarts from PTR = 0.
- RST and CLR high together: RST dominates, with identical result.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When a read address equals a write address being written this cycle (enabled, valid, nonzero, BUSY=0), RDx returns the incoming write data in the same cycle.
  - If both write ports target that address, WD4 is returned.
- REGFILE_BYPASS_EN undefined:
  - RDx returns the stored value.
  - The new value is visible from the cycle after the write edge.

## Test plan
- RST high 1 cycle, DEPTH=32 → BUSY=1 for 32 cycles then 0. A WE3 write of 0xDEADBEEF to 5 during BUSY is lost: RD1(A1=5)=0 after BUSY falls.
- BUSY=0, write WE3 A3=7 WD3=0x11, WE4 A4=9 WD4=0x22 same edge → next cycle RD1(7)=0x11, RD2(9)=0x22, COLLIDE=0.
- WE3 A3=4 WD3=0xAAAA, WE4 A4=4 WD4=0x5555 → RD1(4)=0x5555, COLLIDE=1 for one cycle, then 0.
- Write 0xFFFFFFFF to address 0, and to address 40 with DEPTH=32, REG_ADDR=6 → RD1(0)=0, RD2(40)=0, no other entry changes.
- Bypass: A1=A3=3, WE3=1, WD3=0x1234 → RD1=0x1234 in the same cycle with REGFILE_BYPASS_EN, otherwise the old value 0 until after the edge.
- Fill registers 1–31 with nonzero data, pulse CLR, pulse CLR again 10 cycles later → BUSY stays high 10+32 cycles in total, then every register reads 0.
